// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared types and constants for the acc_drain repeated-subtraction unit.
//   state_e        FSM states S_IDLE, S_DRAIN, S_DONE
//   WIDTH_DEF      default operand / quotient / remainder width
//   QUOT_ALL_ONES  all-ones pattern reported as the quotient on divide-by-zero
//                  (sliced to WIDTH at the point of use)
package acc_drain_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic [63:0] QUOT_ALL_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/drain_sub.sv
// drain_sub: combinational WIDTH-bit subtractor producing {borrow, diff}.
// It is the mirror of the accumulator's {overflow, sum} adder.
//   i_minuend     running value
//   i_subtrahend  step subtracted from it
//   o_diff        i_minuend - i_subtrahend (modulo 2^WIDTH)
//   o_borrow      1 when i_subtrahend > i_minuend
module drain_sub
  import acc_drain_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
);

  // Zero-extend by one bit so the MSB of the result is the borrow out.
  assign {o_borrow, o_diff} = {1'b0, i_minuend} - {1'b0, i_subtrahend};

endmodule

// File: rtl/acc_drain.sv
// acc_drain: sequential repeated-subtraction unit. Loads a dividend, subtracts the divisor once
// per clock until the running value falls below it, then reports quotient and remainder.
//   clock        rising-edge clock
//   clear        synchronous active-high reset, highest priority
//   start        request, sampled only in idle
//   dividend     value to drain, latched on accepted start
//   divisor      step per cycle, latched on accepted start
//   abort        (only with ACC_DRAIN_ABORT_EN) stop a drain early, keeping partial results
//   busy         high from the cycle after an accepted start through the done cycle
//   done         one-cycle pulse; results valid from this cycle onward
//   quotient     number of subtractions performed
//   remainder    residue
//   div_by_zero  latched divisor was zero
// Optional feature macro: ACC_DRAIN_ABORT_EN adds the abort input.
// All outputs come straight from registers.
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef ACC_DRAIN_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] w_quot_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] w_divisor_nxt;
  logic             r_dbz;
  logic             w_dbz_nxt;

  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;

  drain_sub #(
    .WIDTH(WIDTH)
  ) u_sub (
    .i_minuend   (r_rem),
    .i_subtrahend(r_divisor),
    .o_diff      (w_diff),
    .o_borrow    (w_borrow)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_quot    <= w_quot_nxt;
      r_rem     <= w_rem_nxt;
      r_divisor <= w_divisor_nxt;
      r_dbz     <= w_dbz_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_quot_nxt    = r_quot;
    w_rem_nxt     = r_rem;
    w_divisor_nxt = r_divisor;
    w_dbz_nxt     = r_dbz;

    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_divisor_nxt = divisor;
          w_rem_nxt     = dividend;
          w_quot_nxt    = '0;
          w_dbz_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          if (divisor == '0) begin
            // Skip draining entirely; remainder keeps the dividend.
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_dbz_nxt   = 1'b1;
            w_quot_nxt  = QUOT_ALL_ONES[WIDTH-1:0];
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
`ifdef ACC_DRAIN_ABORT_EN
        // Abort wins over this cycle's subtraction so the partial results are left untouched.
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else
`endif
        if (!w_borrow) begin
          w_rem_nxt  = w_diff;
          w_quot_nxt = r_quot + 1'b1;
        end else begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here; the earliest re-accept is the next idle cycle.
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_acc_drain.sv
module tb_acc_drain;

  logic       clock;
  logic       clear;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int vectors;
  int miscompares;

  acc_drain #(
    .WIDTH(8)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef ACC_DRAIN_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive start at a negedge so it is sampled by the next posedge (cycle 0); returns in cycle 1.
  task automatic start_op(input logic [7:0] dvd, input logic [7:0] dvs);
    @(negedge clock);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Samples at each negedge from cycle from_c; reports done cycle (-1 on timeout) and busy history.
  task automatic wait_done(input int from_c, input int budget, output int done_c,
                           output bit busy_ok);
    done_c  = -1;
    busy_ok = 1'b1;
    for (int c = from_c; c < from_c + budget; c++) begin
      @(negedge clock);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_200_7();
    int dc;
    bit bok;
    start_op(8'd200, 8'd7);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 30) begin miscompares++; $display("FAIL 200/7 done cycle: got %0d want 30", dc); end
    vectors++;
    if (bok !== 1'b1) begin miscompares++; $display("FAIL 200/7 busy: dropped before done"); end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {8'd28, 8'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL 200/7 result: got q=%0d r=%0d dbz=%b want q=28 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    vectors++;
    if ({busy, done, quotient, remainder} !== {1'b0, 1'b0, 8'd28, 8'd4}) begin
      miscompares++;
      $display("FAIL 200/7 after done: got busy=%b done=%b q=%0d r=%0d want 0 0 28 4",
               busy, done, quotient, remainder);
    end
  endtask

  task automatic test_small();
    int dc;
    bit bok;
    start_op(8'd5, 8'd9);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 2 || bok !== 1'b1) begin
      miscompares++;
      $display("FAIL 5/9 timing: got done cycle %0d busy_ok %b want 2 1", dc, bok);
    end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {8'd0, 8'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL 5/9 result: got q=%0d r=%0d dbz=%b want 0 5 0",
               quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_max();
    int dc;
    bit bok;
    start_op(8'd255, 8'd1);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 257 || bok !== 1'b1) begin
      miscompares++;
      $display("FAIL 255/1 timing: got done cycle %0d busy_ok %b want 257 1", dc, bok);
    end
    vectors++;
    if ({quotient, remainder} !== {8'd255, 8'd0}) begin
      miscompares++;
      $display("FAIL 255/1 result: got q=%0d r=%0d want 255 0", quotient, remainder);
    end
  endtask

  task automatic test_div_by_zero();
    int dc;
    bit bok;
    start_op(8'd13, 8'd0);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 1 || bok !== 1'b1) begin
      miscompares++;
      $display("FAIL 13/0 timing: got done cycle %0d busy_ok %b want 1 1", dc, bok);
    end
    vectors++;
    if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'd13, 1'b1}) begin
      miscompares++;
      $display("FAIL 13/0 result: got q=%0h r=%0d dbz=%b want ff 13 1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clock);
    vectors++;
    if ({busy, done, div_by_zero} !== 3'b001) begin
      miscompares++;
      $display("FAIL 13/0 after done: got busy=%b done=%b dbz=%b want 0 0 1",
               busy, done, div_by_zero);
    end
  endtask

  task automatic test_zero_dividend();
    int dc;
    bit bok;
    start_op(8'd0, 8'd5);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 2 || {quotient, remainder, div_by_zero} !== {8'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL 0/5: got done cycle %0d q=%0d r=%0d dbz=%b want 2 0 0 0",
               dc, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_clear_mid();
    int dc;
    bit bok;
    bit seen_done;
    start_op(8'd200, 8'd7);
    repeat (10) @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    vectors++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      miscompares++;
      $display("FAIL clear mid: got busy=%b done=%b q=%0d r=%0d dbz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++;
      $display("FAIL clear no done: got activity=%b want 0", seen_done);
    end
    start_op(8'd9, 8'd3);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 5 || {quotient, remainder} !== {8'd3, 8'd0}) begin
      miscompares++;
      $display("FAIL 9/3 after clear: got done cycle %0d q=%0d r=%0d want 5 3 0",
               dc, quotient, remainder);
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    bit bok;
    start_op(8'd100, 8'd10);
    repeat (4) @(negedge clock);
    dividend = 8'd60;
    divisor  = 8'd6;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(5, 300, dc, bok);
    vectors++;
    if (dc !== 12 || bok !== 1'b1) begin
      miscompares++;
      $display("FAIL busy restart timing: got done cycle %0d busy_ok %b want 12 1", dc, bok);
    end
    vectors++;
    if ({quotient, remainder} !== {8'd10, 8'd0}) begin
      miscompares++;
      $display("FAIL busy restart result: got q=%0d r=%0d want 10 0", quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    bit bok;
    start_op(8'd20, 8'd6);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 5 || {quotient, remainder} !== {8'd3, 8'd2}) begin
      miscompares++;
      $display("FAIL 20/6: got done cycle %0d q=%0d r=%0d want 5 3 2", dc, quotient, remainder);
    end
    // Start pulsed only during the done cycle must be dropped.
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    vectors++;
    if ({busy, quotient, remainder} !== {1'b0, 8'd3, 8'd2}) begin
      miscompares++;
      $display("FAIL start in done: got busy=%b q=%0d r=%0d want 0 3 2",
               busy, quotient, remainder);
    end
    start_op(8'd17, 8'd4);
    wait_done(1, 300, dc, bok);
    vectors++;
    if (dc !== 6 || {quotient, remainder} !== {8'd4, 8'd1}) begin
      miscompares++;
      $display("FAIL 17/4: got done cycle %0d q=%0d r=%0d want 6 4 1", dc, quotient, remainder);
    end
  endtask

`ifdef ACC_DRAIN_ABORT_EN
  task automatic test_abort();
    bit seen_done;
    start_op(8'd200, 8'd7);
    repeat (5) @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    vectors++;
    if ({busy, done, quotient, remainder} !== {1'b0, 1'b0, 8'd4, 8'd172}) begin
      miscompares++;
      $display("FAIL abort: got busy=%b done=%b q=%0d r=%0d want 0 0 4 172",
               busy, done, quotient, remainder);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0 || {quotient, remainder} !== {8'd4, 8'd172}) begin
      miscompares++;
      $display("FAIL abort hold: got done_seen=%b q=%0d r=%0d want 0 4 172",
               seen_done, quotient, remainder);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    dividend    = 8'd0;
    divisor     = 8'd0;
    test_reset();
    test_200_7();
    test_small();
    test_max();
    test_div_by_zero();
    test_zero_dividend();
    test_clear_mid();
    test_start_while_busy();
    test_back_to_back();
`ifdef ACC_DRAIN_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
